// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter and write sequencer for the write port
// of an async FIFO. One producer owns the port at a time for a burst of up to
// MAX_BURST words. Write enable and data toward the FIFO are registered, and
// the port stalls while the FIFO reports almost-full.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                          w_clk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                          f_afull,
  output logic [NUM_REQ-1:0]            wr_ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         d_out,
  output logic                          w_en,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        owner;
  logic [IDX_W-1:0]        rr_ptr;
  logic [7:0]              burst_cnt;

  logic [IDX_W-1:0]        pick;
  logic [IDX_W-1:0]        scan_idx;
  logic                    pick_valid;
  logic                    owner_req;
  logic                    accept;
  logic                    last_word;
  logic [DATA_WIDTH-1:0]   owner_data;

  // Round-robin search: first requester strictly after the last owner, wrapping.
  always_comb begin
    pick       = rr_ptr;
    pick_valid = 1'b0;
    scan_idx   = rr_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_valid && wr_req[scan_idx]) begin
        pick       = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

  // Grant is decoded purely from registered state so it cannot glitch.
  always_comb begin
    grant = '0;
    if (state == BURST) begin
      grant[owner] = 1'b1;
    end
  end

  assign owner_req  = wr_req[owner];
  assign owner_data = data_in[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
  assign accept     = (state == BURST) && owner_req && !f_afull;
  assign last_word  = (burst_cnt == 8'(MAX_BURST - 1));
  assign wr_ack     = grant & wr_req & {NUM_REQ{~f_afull}};
  assign busy       = (state == BURST);

  // Arbitration/burst FSM plus the registered write port toward the FIFO.
  always_ff @(posedge w_clk or posedge wrst) begin
    if (wrst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      burst_cnt <= 8'd0;
      w_en      <= 1'b0;
      d_out     <= '0;
    end else begin
      w_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick;
            rr_ptr    <= pick;
            burst_cnt <= 8'd0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (!owner_req) begin
            state <= IDLE;
          end else if (accept) begin
            w_en      <= 1'b1;
            d_out     <= owner_data;
            burst_cnt <= burst_cnt + 8'd1;
            if (last_word) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench for fifo_wr_arbiter.
// Producers are queues of words. A word is popped when its wr_ack is seen.
// Expected FIFO writes are queued in hand-derived order, and a monitor pops
// one entry on every w_en cycle.
module tb_fifo_wr_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MB = 8;

  logic             w_clk = 1'b0;
  logic             wrst  = 1'b1;
  logic [NR-1:0]    wr_req;
  logic [NR*DW-1:0] data_in;
  logic             f_afull;
  logic [NR-1:0]    wr_ack;
  logic [NR-1:0]    grant;
  logic [DW-1:0]    d_out;
  logic             w_en;
  logic             busy;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .MAX_BURST (MB)
  ) dut (
    .w_clk  (w_clk),
    .wrst   (wrst),
    .wr_req (wr_req),
    .data_in(data_in),
    .f_afull(f_afull),
    .wr_ack (wr_ack),
    .grant  (grant),
    .d_out  (d_out),
    .w_en   (w_en),
    .busy   (busy)
  );

  always #5 w_clk = ~w_clk;

  logic [DW-1:0] prod_q [NR][$];
  logic [DW-1:0] exp_q[$];
  logic [NR-1:0] grant_log[$];
  logic [NR-1:0] exp_grants[$];

  int            n_vec    = 0;
  int            n_err    = 0;
  int            n_writes = 0;
  int            w_start  = 0;
  logic          afull_drive = 1'b0;
  logic [NR-1:0] ack_s;
  logic [NR-1:0] grant_s;
  logic          busy_s;
  logic          prev_busy = 1'b0;

  function automatic logic [DW-1:0] mk(input int p, input int t, input int i);
    return {8'(p), 8'(t), 16'(i)};
  endfunction

  // Compare one value and log a miscompare with both values.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle: inputs change on the falling edge, acked words are popped after the rising edge.
  task automatic applyStimulus();
    @(negedge w_clk);
    for (int i = 0; i < NR; i++) begin
      wr_req[i]          = (prod_q[i].size() > 0);
      data_in[i*DW +: DW] = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
    end
    f_afull = afull_drive;
    #1;
    ack_s   = wr_ack;
    grant_s = grant;
    busy_s  = busy;
    if (busy_s && !prev_busy) grant_log.push_back(grant_s);
    prev_busy = busy_s;
    @(posedge w_clk);
    for (int i = 0; i < NR; i++) begin
      if (ack_s[i]) void'(prod_q[i].pop_front());
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic load(input int p, input int t, input int n);
    for (int i = 0; i < n; i++) prod_q[p].push_back(mk(p, t, i));
  endtask

  task automatic expectWords(input int p, input int t, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(mk(p, t, i));
  endtask

  task automatic holdReset();
    wrst    = 1'b1;
    wr_req  = '0;
    f_afull = 1'b0;
    for (int i = 0; i < NR; i++) prod_q[i].delete();
    grant_log.delete();
    prev_busy = 1'b0;
    repeat (2) @(negedge w_clk);
    wrst = 1'b0;
  endtask

  task automatic finishTest(input string name);
    checkOutput({name, " drained"}, exp_q.size(), 0);
    checkOutput({name, " bursts"}, grant_log.size(), exp_grants.size());
    for (int i = 0; i < exp_grants.size() && i < grant_log.size(); i++) begin
      checkOutput({name, " grant order"}, 32'(grant_log[i]), 32'(exp_grants[i]));
    end
    grant_log.delete();
    exp_grants.delete();
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected word.
  always @(negedge w_clk) begin
    if (!wrst && w_en) begin
      n_writes++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected write: got %h, expected no write", d_out);
      end else begin
        automatic logic [DW-1:0] e = exp_q.pop_front();
        if (d_out !== e) begin
          n_err++;
          $display("[TB] FAIL write data: got %h, expected %h", d_out, e);
        end
      end
    end
  end

  initial begin
    wr_req  = '1;
    data_in = '1;
    f_afull = 1'b0;

    // Reset state with every producer requesting.
    #12;
    checkOutput("rst w_en", w_en, 0);
    checkOutput("rst d_out", d_out, 0);
    checkOutput("rst grant", grant, 0);
    checkOutput("rst wr_ack", wr_ack, 0);
    checkOutput("rst busy", busy, 0);
    @(negedge w_clk);
    wr_req = '0;
    wrst   = 1'b0;

    // Reset asserted mid-burst drops it at once; the first grant afterwards is req0.
    load(2, 1, 5);
    expectWords(2, 1, 0, 2);
    run(4);
    @(negedge w_clk);
    #2;
    wrst = 1'b1;
    #1;
    checkOutput("t1 rst w_en", w_en, 0);
    checkOutput("t1 rst grant", grant, 0);
    checkOutput("t1 rst wr_ack", wr_ack, 0);
    checkOutput("t1 rst busy", busy, 0);
    checkOutput("t1 rst d_out", d_out, 0);
    holdReset();
    load(0, 11, 2);
    load(1, 11, 2);
    expectWords(0, 11, 0, 1);
    expectWords(1, 11, 0, 1);
    exp_grants.push_back(4'b0001);
    exp_grants.push_back(4'b0010);
    run(10);
    finishTest("t1");

    // Single producer, three words, one arbitration cycle before the first write.
    load(1, 2, 3);
    expectWords(1, 2, 0, 2);
    exp_grants.push_back(4'b0010);
    w_start = n_writes;
    applyStimulus();
    checkOutput("t2 idle ack", ack_s, 0);
    checkOutput("t2 idle busy", busy_s, 0);
    #1 checkOutput("t2 idle w_en", w_en, 0);
    applyStimulus();
    checkOutput("t2 first ack", ack_s, 4'b0010);
    #1 checkOutput("t2 first w_en", w_en, 1);
    run(5);
    checkOutput("t2 write count", n_writes - w_start, 3);
    finishTest("t2");

    // Burst limit: req0 capped at eight words, one idle cycle, then req2.
    holdReset();
    load(0, 3, 20);
    load(2, 3, 10);
    expectWords(0, 3, 0, 7);
    expectWords(2, 3, 0, 7);
    expectWords(0, 3, 8, 15);
    expectWords(2, 3, 8, 9);
    expectWords(0, 3, 16, 19);
    exp_grants.push_back(4'b0001);
    exp_grants.push_back(4'b0100);
    exp_grants.push_back(4'b0001);
    exp_grants.push_back(4'b0100);
    exp_grants.push_back(4'b0001);
    run(9);
    checkOutput("t3 last ack", ack_s, 4'b0001);
    applyStimulus();
    checkOutput("t3 gap busy", busy_s, 0);
    checkOutput("t3 gap ack", ack_s, 0);
    applyStimulus();
    checkOutput("t3 next grant", grant_s, 4'b0100);
    run(40);
    finishTest("t3");

    // Round robin with all four producers requesting continuously.
    holdReset();
    for (int p = 0; p < NR; p++) load(p, 4, 12);
    for (int p = 0; p < NR; p++) begin
      expectWords(p, 4, 0, 7);
      exp_grants.push_back(4'(1 << p));
    end
    for (int p = 0; p < NR; p++) begin
      expectWords(p, 4, 8, 11);
      exp_grants.push_back(4'(1 << p));
    end
    run(70);
    finishTest("t4");

    // Backpressure for five cycles mid-burst; the burst resumes at the same count.
    holdReset();
    load(1, 5, 10);
    load(3, 5, 2);
    expectWords(1, 5, 0, 7);
    expectWords(3, 5, 0, 1);
    expectWords(1, 5, 8, 9);
    exp_grants.push_back(4'b0010);
    exp_grants.push_back(4'b1000);
    exp_grants.push_back(4'b0010);
    run(4);
    afull_drive = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput("t5 stall ack", ack_s, 0);
      checkOutput("t5 stall grant", grant_s, 4'b0010);
      #1 checkOutput("t5 stall w_en", w_en, 0);
    end
    afull_drive = 1'b0;
    run(30);
    finishTest("t5");

    // Early drop: the owner releases its request after two words.
    holdReset();
    load(0, 6, 2);
    load(2, 6, 3);
    expectWords(0, 6, 0, 1);
    expectWords(2, 6, 0, 2);
    exp_grants.push_back(4'b0001);
    exp_grants.push_back(4'b0100);
    run(3);
    applyStimulus();
    checkOutput("t6 drop ack", ack_s, 0);
    checkOutput("t6 drop busy", busy_s, 1);
    #1;
    checkOutput("t6 drop w_en", w_en, 0);
    checkOutput("t6 drop idle", busy, 0);
    applyStimulus();
    checkOutput("t6 arb busy", busy_s, 0);
    applyStimulus();
    checkOutput("t6 next grant", grant_s, 4'b0100);
    run(6);
    finishTest("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
